// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: drives ALU/datapath selects from state; 3-5 cycles per instruction.
// Memory strobes hold until MEM_READY; illegal opcodes park in a sticky halt until RST.
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] OPCODE,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic [3:0]  ALU_CTRL,
  output logic [1:0]  ALU_SRC_A,
  output logic [1:0]  ALU_SRC_B,
  output logic        PC_WRITE,
  output logic        PC_SRC,
  output logic        IR_WRITE,
  output logic        I_OR_D,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        REG_WRITE,
  output logic        MEM_TO_REG,
  output logic        REG2_LOC,
  output logic        HALTED
);

  typedef enum logic [3:0] {
    st_fetch, st_decode, st_exec_r, st_wb_r, st_addr, st_mem_rd,
    st_wb_ld, st_mem_wr, st_cbz_ex, st_br, st_halt
  } state_t;

  state_t state;

  logic is_add, is_sub, is_and, is_orr, is_r, is_ldur, is_stur, is_cbz, is_b;

  assign is_add  = (OPCODE == 11'h458);
  assign is_sub  = (OPCODE == 11'h658);
  assign is_and  = (OPCODE == 11'h450);
  assign is_orr  = (OPCODE == 11'h550);
  assign is_r    = is_add | is_sub | is_and | is_orr;
  assign is_ldur = (OPCODE == 11'h7C2);
  assign is_stur = (OPCODE == 11'h7C0);
  assign is_cbz  = (OPCODE[10:3] == 8'hB4);     // 0x5A0-0x5A7
  assign is_b    = (OPCODE[10:5] == 6'b000101); // 0x0A0-0x0BF

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= st_fetch;
    end else begin
      case (state)
        st_fetch:  if (MEM_READY) state <= st_decode;
        st_decode: begin
          if (is_r)                   state <= st_exec_r;
          else if (is_ldur | is_stur) state <= st_addr;
          else if (is_cbz)            state <= st_cbz_ex;
          else if (is_b)              state <= st_br;
          else                        state <= st_halt;
        end
        st_exec_r: state <= st_wb_r;
        st_wb_r:   state <= st_fetch;
        st_addr:   state <= is_ldur ? st_mem_rd : st_mem_wr;
        st_mem_rd: if (MEM_READY) state <= st_wb_ld;
        st_wb_ld:  state <= st_fetch;
        st_mem_wr: if (MEM_READY) state <= st_fetch;
        st_cbz_ex: state <= st_fetch;
        st_br:     state <= st_fetch;
        st_halt:   state <= st_halt;
        default:   state <= st_fetch;
      endcase
    end
  end

  // Outputs are decoded combinationally and forced low for as long as RST is held.
  always_comb begin
    ALU_CTRL   = 4'd0;
    ALU_SRC_A  = 2'd0;
    ALU_SRC_B  = 2'd0;
    PC_WRITE   = 1'b0;
    PC_SRC     = 1'b0;
    IR_WRITE   = 1'b0;
    I_OR_D     = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    REG_WRITE  = 1'b0;
    MEM_TO_REG = 1'b0;
    REG2_LOC   = 1'b0;
    HALTED     = 1'b0;
    if (!RST) begin
      case (state)
        st_fetch: begin
          MEM_READ  = 1'b1;
          ALU_SRC_B = 2'd1;
          ALU_CTRL  = 4'd2;
          IR_WRITE  = MEM_READY;
          PC_WRITE  = MEM_READY;
        end
        st_decode: begin
          ALU_SRC_A = 2'd2;
          ALU_SRC_B = 2'd3;
          ALU_CTRL  = 4'd2;
          REG2_LOC  = is_stur | is_cbz;
        end
        st_exec_r: begin
          ALU_SRC_A = 2'd1;
          if (is_sub)      ALU_CTRL = 4'd6;
          else if (is_and) ALU_CTRL = 4'd0;
          else if (is_orr) ALU_CTRL = 4'd1;
          else             ALU_CTRL = 4'd2;
        end
        st_wb_r:   REG_WRITE = 1'b1;
        st_addr: begin
          ALU_SRC_A = 2'd1;
          ALU_SRC_B = 2'd2;
          ALU_CTRL  = 4'd2;
        end
        st_mem_rd: begin
          MEM_READ = 1'b1;
          I_OR_D   = 1'b1;
        end
        st_wb_ld: begin
          REG_WRITE  = 1'b1;
          MEM_TO_REG = 1'b1;
        end
        st_mem_wr: begin
          MEM_WRITE = 1'b1;
          I_OR_D    = 1'b1;
        end
        st_cbz_ex: begin
          ALU_CTRL = 4'd7;
          PC_WRITE = ZERO;
          PC_SRC   = 1'b1;
        end
        st_br: begin
          PC_WRITE = 1'b1;
          PC_SRC   = 1'b1;
        end
        st_halt:   HALTED = 1'b1;
        default:   HALTED = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle compares the full output vector to a hand-built expectation.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [10:0] OPCODE;
  logic        ZERO;
  logic        MEM_READY;
  logic [3:0]  ALU_CTRL;
  logic [1:0]  ALU_SRC_A, ALU_SRC_B;
  logic        PC_WRITE, PC_SRC, IR_WRITE, I_OR_D, MEM_READ, MEM_WRITE;
  logic        REG_WRITE, MEM_TO_REG, REG2_LOC, HALTED;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .ALU_CTRL(ALU_CTRL), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .PC_WRITE(PC_WRITE), .PC_SRC(PC_SRC), .IR_WRITE(IR_WRITE), .I_OR_D(I_OR_D),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .REG_WRITE(REG_WRITE),
    .MEM_TO_REG(MEM_TO_REG), .REG2_LOC(REG2_LOC), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // flag bit positions inside the 18-bit observation vector
  localparam logic [9:0] PCW = 10'b10_0000_0000;
  localparam logic [9:0] PCS = 10'b01_0000_0000;
  localparam logic [9:0] IRW = 10'b00_1000_0000;
  localparam logic [9:0] IOD = 10'b00_0100_0000;
  localparam logic [9:0] MR  = 10'b00_0010_0000;
  localparam logic [9:0] MW  = 10'b00_0001_0000;
  localparam logic [9:0] RW  = 10'b00_0000_1000;
  localparam logic [9:0] M2R = 10'b00_0000_0100;
  localparam logic [9:0] R2  = 10'b00_0000_0010;
  localparam logic [9:0] H   = 10'b00_0000_0001;

  function automatic logic [17:0] o(input int alu, input int sa, input int sb, input logic [9:0] f);
    return {alu[3:0], sa[1:0], sb[1:0], f};
  endfunction

  function automatic logic [17:0] obs();
    return {ALU_CTRL, ALU_SRC_A, ALU_SRC_B, PC_WRITE, PC_SRC, IR_WRITE, I_OR_D,
            MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG, REG2_LOC, HALTED};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // compare outputs mid-cycle, then advance to 1ns after the next rising edge
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    check(tag, {14'd0, obs()}, {14'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  localparam logic [17:0] FETCH_RDY  = {4'd2, 2'd0, 2'd1, PCW | IRW | MR};
  localparam logic [17:0] FETCH_WAIT = {4'd2, 2'd0, 2'd1, MR};

  logic [10:0] rops [4] = '{11'h458, 11'h658, 11'h450, 11'h550};
  int          ralu [4] = '{2, 6, 0, 1};

  initial begin
    RST = 1'b1; OPCODE = 11'h000; ZERO = 1'b0; MEM_READY = 1'b1;
    @(posedge CLK); #1;
    cyc("reset0", 18'd0);
    cyc("reset1", 18'd0);
    RST = 1'b0;

    for (int i = 0; i < 4; i++) begin
      OPCODE = rops[i];
      cyc($sformatf("r%0d_fetch", i),  FETCH_RDY);
      cyc($sformatf("r%0d_decode", i), o(2, 2, 3, 10'd0));
      cyc($sformatf("r%0d_exec", i),   o(ralu[i], 1, 0, 10'd0));
      cyc($sformatf("r%0d_wb", i),     o(0, 0, 0, RW));
    end

    OPCODE = 11'h7C2; MEM_READY = 1'b0;
    cyc("ld_fwait0", FETCH_WAIT);
    cyc("ld_fwait1", FETCH_WAIT);
    MEM_READY = 1'b1;
    cyc("ld_fetch",  FETCH_RDY);
    cyc("ld_decode", o(2, 2, 3, 10'd0));
    cyc("ld_addr",   o(2, 1, 2, 10'd0));
    MEM_READY = 1'b0;
    cyc("ld_mwait0", o(0, 0, 0, MR | IOD));
    cyc("ld_mwait1", o(0, 0, 0, MR | IOD));
    MEM_READY = 1'b1;
    cyc("ld_mem",    o(0, 0, 0, MR | IOD));
    cyc("ld_wb",     o(0, 0, 0, RW | M2R));

    OPCODE = 11'h5A3; ZERO = 1'b1;
    cyc("cbz1_fetch",  FETCH_RDY);
    cyc("cbz1_decode", o(2, 2, 3, R2));
    cyc("cbz1_taken",  o(7, 0, 0, PCW | PCS));
    ZERO = 1'b0;
    cyc("cbz0_fetch",  FETCH_RDY);
    cyc("cbz0_decode", o(2, 2, 3, R2));
    cyc("cbz0_not",    o(7, 0, 0, PCS));

    foreach (rops[i]) begin end
    OPCODE = 11'h0A5;
    cyc("b_fetch",  FETCH_RDY);
    cyc("b_decode", o(2, 2, 3, 10'd0));
    cyc("b_br",     o(0, 0, 0, PCW | PCS));
    OPCODE = 11'h0BF;
    cyc("bmax_fetch",  FETCH_RDY);
    cyc("bmax_decode", o(2, 2, 3, 10'd0));
    cyc("bmax_br",     o(0, 0, 0, PCW | PCS));

    OPCODE = 11'h7C0;
    cyc("st_fetch",  FETCH_RDY);
    cyc("st_decode", o(2, 2, 3, R2));
    cyc("st_addr",   o(2, 1, 2, 10'd0));
    cyc("st_mem",    o(0, 0, 0, MW | IOD));
    cyc("st_next",   FETCH_RDY);
    OPCODE = 11'h000;
    cyc("hlt_decode", o(2, 2, 3, 10'd0));
    for (int i = 0; i < 20; i++) begin
      MEM_READY = i[0];
      cyc($sformatf("hlt_%0d", i), o(0, 0, 0, H));
    end
    RST = 1'b1;
    cyc("hlt_rst", 18'd0);
    RST = 1'b0; MEM_READY = 1'b1;

    // first code just past the CBZ range must be rejected
    OPCODE = 11'h5A8;
    cyc("ill_fetch",  FETCH_RDY);
    cyc("ill_decode", o(2, 2, 3, 10'd0));
    cyc("ill_halt0",  o(0, 0, 0, H));
    cyc("ill_halt1",  o(0, 0, 0, H));
    RST = 1'b1;
    cyc("ill_rst", 18'd0);
    RST = 1'b0;

    OPCODE = 11'h7C0;
    cyc("sr_fetch",  FETCH_RDY);
    cyc("sr_decode", o(2, 2, 3, R2));
    cyc("sr_addr",   o(2, 1, 2, 10'd0));
    MEM_READY = 1'b0;
    cyc("sr_wait",   o(0, 0, 0, MW | IOD));
    RST = 1'b1;
    cyc("sr_rst",    18'd0);
    RST = 1'b0;
    cyc("sr_fetch_w", FETCH_WAIT);
    MEM_READY = 1'b1;
    cyc("sr_fetch_r", FETCH_RDY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle LEGv8 control unit: the initiator side of the ALU interface. It drives ALU_CTRL and the datapath operand/write-enable selects each cycle, consumes the ALU ZERO flag for CBZ, and handshakes instruction and data memory accesses through MEM_READY. It sits between the instruction register (opcode field) and the multicycle datapath (PC, OLD_PC, IR, A/B, ALUOut and MDR registers, register file, memory).

## Interface
- No parameters.
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- OPCODE  in  11  IR[31:21], valid from DECODE onward.
- ZERO  in  1  ALU zero flag, same-cycle combinational.
- MEM_READY  in  1  memory access completes this cycle.
- ALU_CTRL  out  4  0=AND, 1=ORR, 2=ADD, 6=SUB, 7=PASS B.
- ALU_SRC_A  out  2  0=PC, 1=A reg, 2=OLD_PC.
- ALU_SRC_B  out  2  0=B reg, 1=const 4, 2=sign-ext DT address, 3=sign-ext branch offset<<2.
- PC_WRITE, PC_SRC  out  1,1  PC load; PC_SRC 0=ALU result, 1=ALUOut.
- IR_WRITE  out  1  loads IR and OLD_PC←PC.
- I_OR_D  out  1  memory address 0=PC, 1=ALUOut.
- MEM_READ, MEM_WRITE  out  1,1  memory strobes, held until MEM_READY.
- REG_WRITE, MEM_TO_REG  out  1,1  regfile write; data 0=ALUOut, 1=MDR.
- REG2_LOC  out  1  read port 2 address 0=Rm, 1=Rt.
- HALTED  out  1  sticky illegal-opcode indicator.

## Operation
- Decoded opcodes: ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550, LDUR 0x7C2, STUR 0x7C0, CBZ 0x5A0–0x5A7, B 0x0A0–0x0BF. All others illegal.
- States and outputs (unlisted outputs 0):
- FETCH: MEM_READ=1, I_OR_D=0, ALU_SRC_A=0, ALU_SRC_B=1, ALU_CTRL=2. While MEM_READY=0 stay. When MEM_READY=1: IR_WRITE=1, PC_WRITE=1, PC_SRC=0; → DECODE.
- DECODE: ALU_SRC_A=2, ALU_SRC_B=3, ALU_CTRL=2 (ALUOut←branch target); REG2_LOC=1 for STUR/CBZ. → EXEC_R (R-type), ADDR (LDUR/STUR), CBZ_EX, BR, or HALT (illegal).
- EXEC_R: ALU_SRC_A=1, ALU_SRC_B=0, ALU_CTRL per op (ADD 2, SUB 6, AND 0, ORR 1). → WB_R.
- WB_R: REG_WRITE=1, MEM_TO_REG=0. → FETCH.
- ADDR: ALU_SRC_A=1, ALU_SRC_B=2, ALU_CTRL=2. → MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MEM_READ=1, I_OR_D=1; wait for MEM_READY. → WB_LD.
- WB_LD: REG_WRITE=1, MEM_TO_REG=1. → FETCH.
- MEM_WR: MEM_WRITE=1, I_OR_D=1; wait for MEM_READY. → FETCH.
- CBZ_EX: ALU_SRC_B=0, ALU_CTRL=7; PC_WRITE=ZERO, PC_SRC=1. → FETCH.
- BR: PC_WRITE=1, PC_SRC=1. → FETCH.
- HALT: all strobes 0, HALTED=1; exit only via RST.
- OPCODE is sampled in DECODE, EXEC_R and ADDR; the IR is stable there because IR_WRITE is asserted only in FETCH.

## Timing
- Reset: RST high at a rising edge → state FETCH next cycle. While RST=1 all outputs are forced to 0, including strobes, selects, ALU_CTRL and HALTED.
- Reset mid-access abandons the access. No strobe is asserted in the cycle following the reset edge except FETCH's MEM_READ, and only once RST has deasserted.
- Outputs are combinational from state, plus MEM_READY (FETCH) and ZERO (CBZ_EX). No output is registered.
- Cycle counts with MEM_READY already high:
  - R-type 4 cycles.
  - LDUR 5 cycles.
  - STUR 4 cycles.
  - CBZ and B 3 cycles each.
- Each memory wait cycle adds 1.
- MEM_READY is ignored outside FETCH, MEM_RD and MEM_WR.
- A MEM_READY asserted in the same cycle as the strobe completes the access in that cycle.

## Test plan
- RST 2 cycles; then MEM_READY=1 and OPCODE=0x458 → FETCH/DECODE/EXEC_R/WB_R. ALU_CTRL=2 in EXEC_R, REG_WRITE=1 only in cycle 4, PC_WRITE=1 only in cycle 1. Repeat for SUB (6), AND (0) and ORR (1).
- OPCODE=0x7C2 with MEM_READY low for 2 cycles in each of FETCH and MEM_RD → 9 cycles total; MEM_READ held high through the waits; WB_LD asserts MEM_TO_REG=1 and REG_WRITE=1.
- OPCODE=0x5A3 twice, once with ZERO=1 and once with ZERO=0 in CBZ_EX → PC_WRITE=1, PC_SRC=1 when taken; PC_WRITE=0 when not taken. REG2_LOC=1 in DECODE. Back in FETCH after 3 cycles either way.
- OPCODE=0x0A5 → BR asserts PC_WRITE=1, PC_SRC=1 in cycle 3. OPCODE=0x7C0 → MEM_WRITE=1, I_OR_D=1 in cycle 4; REG_WRITE never asserted.
- OPCODE=0x000 → HALT; HALTED=1 with all strobes 0 for 20 cycles regardless of MEM_READY. RST then clears HALTED and returns to FETCH.
- RST asserted during a MEM_WR wait → next cycle MEM_WRITE=0 and all outputs 0. After RST drops, FETCH with MEM_READ=1.
